// File: rtl/sd_clk_pkg.sv
// Shared types and default constants for the SD clock generator and its users.
package sd_clk_pkg;

  typedef enum logic {
    StPark = 1'b0,
    StRun  = 1'b1
  } sd_clk_state_e;

  localparam int unsigned SD_SLOW_HALF      = 63;
  localparam int unsigned SD_FAST_HALF_RST  = 1;
  localparam int unsigned SD_SLOW_STATE_LIM = 'h70;

endpackage

// File: rtl/sd_clk_halfcnt.sv
// Half-period counter: counts 0..i_half, flags terminal count, wraps to 0.
module sd_clk_halfcnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // >= keeps the counter bounded even if i_half were ever lowered mid-phase
  assign o_tc = (r_cnt >= i_half);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sd_clk_gen.sv
// Glitch-free two-rate SD clock generator with loadable fast divisor and clock park.
// Optional edge strobes enabled by defining SD_CLK_EDGE_STROBE_EN.
module sd_clk_gen
  import sd_clk_pkg::*;
#(
  parameter int unsigned STATE_W        = 8,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned SLOW_HALF      = SD_SLOW_HALF,
  parameter int unsigned FAST_HALF_RST  = SD_FAST_HALF_RST,
  parameter int unsigned SLOW_STATE_LIM = SD_SLOW_STATE_LIM
) (
  input  logic               CLKin,
  input  logic               Reset,
  input  logic [STATE_W-1:0] State,
  input  logic               clk_en,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_value,
  output logic               CLKout,
  output logic               slow_active,
  output logic               clk_running,
  output logic               rise_stb,
  output logic               fall_stb
);

  sd_clk_state_e    r_state, w_state_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_slow_active, w_slow_nxt;
  logic [CNT_W-1:0] r_fast_half, w_fast_nxt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_cur_half;
  logic             w_slow_req;
  logic             w_run;
  logic             w_tc;

  assign w_slow_req = (State != '0) && (State < STATE_W'(SLOW_STATE_LIM));
  assign w_cur_half = r_slow_active ? CNT_W'(SLOW_HALF) : r_fast_half;
  assign w_run      = (r_state == StRun);

  sd_clk_halfcnt #(
    .CNT_W (CNT_W)
  ) u_halfcnt (
    .i_clk   (CLKin),
    .i_rst_n (Reset),
    .i_clr   (~w_run),
    .i_half  (w_cur_half),
    .o_tc    (w_tc)
  );

  // Latest loaded divisor; only reaches r_fast_half at a commit point.
  always_ff @(posedge CLKin or negedge Reset) begin
    if (!Reset) begin
      r_pend <= CNT_W'(FAST_HALF_RST);
    end else if (div_load) begin
      r_pend <= div_value;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk;
    w_slow_nxt  = r_slow_active;
    w_fast_nxt  = r_fast_half;
    unique case (r_state)
      StPark: begin
        w_slow_nxt = w_slow_req;
        w_fast_nxt = r_pend;
        if (clk_en) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_tc) begin
          w_clk_nxt = ~r_clk;
          // Falling toggle is the only safe point to change rate or stop.
          if (r_clk) begin
            w_slow_nxt = w_slow_req;
            w_fast_nxt = r_pend;
            if (!clk_en) begin
              w_state_nxt = StPark;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLKin or negedge Reset) begin
    if (!Reset) begin
      r_state       <= StPark;
      r_clk         <= 1'b0;
      r_slow_active <= 1'b1;
      r_fast_half   <= CNT_W'(FAST_HALF_RST);
    end else begin
      r_state       <= w_state_nxt;
      r_clk         <= w_clk_nxt;
      r_slow_active <= w_slow_nxt;
      r_fast_half   <= w_fast_nxt;
    end
  end

  assign CLKout      = r_clk;
  assign slow_active = r_slow_active;
  assign clk_running = w_run;

`ifdef SD_CLK_EDGE_STROBE_EN
  assign rise_stb = w_run && w_tc && !r_clk;
  assign fall_stb = w_run && w_tc && r_clk;
`else
  assign rise_stb = 1'b0;
  assign fall_stb = 1'b0;
`endif

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: directed scenarios plus random traffic, checked against a phase-level model.
module tb_sd_clk_gen;

  logic       CLKin = 1'b0;
  logic       Reset;
  logic [7:0] State;
  logic       clk_en;
  logic       div_load;
  logic [7:0] div_value;
  logic       CLKout;
  logic       slow_active;
  logic       clk_running;
  logic       rise_stb;
  logic       fall_stb;

  int total = 0;
  int bad   = 0;

  always #5 CLKin = ~CLKin;

  sd_clk_gen u_dut (
    .CLKin       (CLKin),
    .Reset       (Reset),
    .State       (State),
    .clk_en      (clk_en),
    .div_load    (div_load),
    .div_value   (div_value),
    .CLKout      (CLKout),
    .slow_active (slow_active),
    .clk_running (clk_running),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb)
  );

  // Model: a running clock is a sequence of phases, each lasting half+1 cycles,
  // where half is fixed at the falling edge that opened the low phase.
  bit m_run, m_clk, m_slow;
  int m_fast, m_pend, m_left;

  typedef struct {
    logic lvl;
    int   len;
  } phase_t;
  phase_t phq[$];
  logic   ph_lvl;
  int     ph_len;

  function automatic int m_half();
    return m_slow ? 63 : m_fast;
  endfunction

  task automatic model_reset();
    m_run = 0; m_clk = 0; m_slow = 1; m_fast = 1; m_pend = 1; m_left = 0;
  endtask

  // Advance the model by one CLKin edge using the inputs about to be sampled.
  task automatic model_edge();
    int  old_pend;
    bit  req;
    old_pend = m_pend;
    if (div_load) m_pend = int'(div_value);
    req = (State != 8'h00) && (State < 8'h70);
    if (!m_run) begin
      m_slow = req;
      m_fast = old_pend;
      if (clk_en) begin
        m_run  = 1;
        m_left = m_half() + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_clk) begin
          m_clk  = 0;
          m_slow = req;
          m_fast = old_pend;
          if (!clk_en) m_run = 0;
          else m_left = m_half() + 1;
        end else begin
          m_clk  = 1;
          m_left = m_half() + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: model edge, wait to the next negedge, compare all outputs, track phases.
  task automatic step();
    logic exp_rise, exp_fall;
    if (!Reset) model_reset();
    else model_edge();
    @(negedge CLKin);
`ifdef SD_CLK_EDGE_STROBE_EN
    exp_rise = m_run && (m_left == 1) && !m_clk;
    exp_fall = m_run && (m_left == 1) && m_clk;
`else
    exp_rise = 1'b0;
    exp_fall = 1'b0;
`endif
    chk("clkout", CLKout, m_clk);
    chk("slow_active", slow_active, m_slow);
    chk("clk_running", clk_running, m_run);
    chk("rise_stb", rise_stb, exp_rise);
    chk("fall_stb", fall_stb, exp_fall);
    if (CLKout === ph_lvl) begin
      ph_len++;
    end else begin
      phq.push_back('{lvl: ph_lvl, len: ph_len});
      ph_lvl = CLKout;
      ph_len = 1;
    end
  endtask

  task automatic get_phase(output logic lvl, output int len);
    int n;
    n = 0;
    while (phq.size() == 0 && n < 400) begin
      step();
      n++;
    end
    chk("phase_timeout", (phq.size() != 0), 1'b1);
    if (phq.size() != 0) begin
      lvl = phq[0].lvl;
      len = phq[0].len;
      void'(phq.pop_front());
    end else begin
      lvl = 1'bx;
      len = -1;
    end
  endtask

  task automatic chk_phase(input string tag, input logic exp_lvl, input int exp_len);
    logic l;
    int   n;
    get_phase(l, n);
    chk({tag, "_lvl"}, l, exp_lvl);
    chk({tag, "_len"}, n, exp_len);
  endtask

  task automatic track_reset();
    phq.delete();
    ph_lvl = 1'b0;
    ph_len = 0;
  endtask

  logic [7:0] st_tab[6] = '{8'h00, 8'h10, 8'h6f, 8'h70, 8'h80, 8'h01};

  initial begin
    logic l;
    int   n;
    bit   found;

    Reset = 1'b0; clk_en = 1'b0; State = 8'h10; div_load = 1'b0; div_value = 8'h00;
    model_reset();
    track_reset();
    @(negedge CLKin);
    step();
    step();
    chk("rst_clkout", CLKout, 1'b0);
    chk("rst_slow", slow_active, 1'b1);
    chk("rst_running", clk_running, 1'b0);

    // Slow identification clock: 64-cycle phases
    Reset = 1'b1; clk_en = 1'b1;
    track_reset();
    get_phase(l, n);
    chk_phase("slow_hi", 1'b1, 64);
    chk_phase("slow_lo", 1'b0, 64);

    // Switch to fast; takes effect at the next falling edge only
    State = 8'h00;
    step();
    chk("slow_hold", slow_active, 1'b1);
    chk_phase("sw_hi", 1'b1, 64);
    chk_phase("sw_lo", 1'b0, 2);
    chk_phase("fast_hi", 1'b1, 2);
    chk("fast_mode", slow_active, 1'b0);
    State = 8'h70;
    chk_phase("lim_lo", 1'b0, 2);
    chk_phase("lim_hi", 1'b1, 2);
    chk("lim_mode", slow_active, 1'b0);

    // Back to slow, then request fast 20 cycles into a slow high phase
    State = 8'h10;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      get_phase(l, n);
      if (l === 1'b0 && n == 64) found = 1;
    end
    chk("reach_slow", found, 1'b1);
    for (int i = 0; i < 19; i++) step();
    State = 8'h80;
    chk_phase("mid_hi", 1'b1, 64);
    chk_phase("mid_lo", 1'b0, 2);

    // Divisor load 4 while fast: current phase unaffected
    div_load = 1'b1; div_value = 8'd4;
    step();
    div_load = 1'b0;
    chk_phase("ld4_hi", 1'b1, 2);
    chk_phase("ld4_lo", 1'b0, 5);
    chk_phase("ld4_hi2", 1'b1, 5);
    div_load = 1'b1; div_value = 8'd0;
    step();
    div_load = 1'b0;
    chk_phase("ld0_lo", 1'b0, 5);
    chk_phase("ld0_hi", 1'b1, 5);
    chk_phase("ld0_lo2", 1'b0, 1);
    chk_phase("ld0_hi2", 1'b1, 1);

    // Restore divisor 4, then stop while high
    div_load = 1'b1; div_value = 8'd4;
    step();
    div_load = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      get_phase(l, n);
      if (l === 1'b0 && n == 5) found = 1;
    end
    chk("reach_div4", found, 1'b1);
    clk_en = 1'b0;
    chk_phase("stop_hi", 1'b1, 5);
    for (int i = 0; i < 20; i++) step();
    chk("park_clk", CLKout, 1'b0);
    chk("park_running", clk_running, 1'b0);
    clk_en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (CLKout !== 1'b1 && n < 50);
    chk("first_rise", n, 6);

    // Async reset in the middle of a high phase
    step();
    step();
    #2 Reset = 1'b0;
    #1;
    chk("arst_clkout", CLKout, 1'b0);
    chk("arst_slow", slow_active, 1'b1);
    chk("arst_running", clk_running, 1'b0);
    model_reset();
    @(negedge CLKin);
    Reset = 1'b1;
    track_reset();
    get_phase(l, n);
    chk_phase("post_rst_hi", 1'b1, 2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) State = 8'($urandom);
        else State = st_tab[$urandom_range(0, 5)];
      end
      div_load = ($urandom_range(0, 39) == 0);
      if (div_load) div_value = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) clk_en = ~clk_en;
      step();
    end
    div_load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
- Parametrised SD-card clock generator; next generation of the fixed two-rate SD clock divider.
- Generates registered SD clock CLKout from CLKin with two half-period divisors: slow/identification and fast/transfer.
- Slow vs fast selected from the SD controller State; switching is glitch-free.
- Adds runtime-loadable fast divisor, clock stop/start, and edge strobes. Sits between the SD controller FSM and the SPI/SD pad logic.

Parameters:
- STATE_W, 8, width of controller State input
- CNT_W, 8, width of half-period counter and divisor registers
- SLOW_HALF, 63, slow half-period minus 1 (CLKout toggles every SLOW_HALF+1 CLKin cycles)
- FAST_HALF_RST, 1, reset value of fast half-period register
- SLOW_STATE_LIM, 8'h70, State values 1..SLOW_STATE_LIM-1 request slow mode

Ports:
- CLKin  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- State  in  STATE_W  SD controller state
- clk_en  in  1  1 = CLKout runs, 0 = park CLKout low
- div_load  in  1  one-cycle strobe: load div_value into fast half-period register
- div_value  in  CNT_W  new fast half-period minus 1; 0 is legal (CLKin/2)
- CLKout  out  1  SD clock, flop output
- slow_active  out  1  mode currently applied to CLKout (1 = slow)
- clk_running  out  1  CLKout toggling (0 while parked)
- rise_stb  out  1  optional, see feature
- fall_stb  out  1  optional, see feature

Behaviour:
- Reset (async assert, sync release) values:
  - CLKout=0, cnt=0, slow_active=1, clk_running=0.
  - fast_half=FAST_HALF_RST, rise_stb=fall_stb=0.
- Requests are decoded combinationally each cycle:
  - slow_req = (State!=0 && State<SLOW_STATE_LIM).
  - run_req = clk_en.
- cur_half = slow_active ? SLOW_HALF : fast_half (CNT_W bits, zero-extended).
- States:
  - PARKED (CLKout=0, clk_running=0):
    - cnt held 0; slow_active and fast_half updates are applied immediately.
    - When run_req=1: go to RUN next cycle; clk_running=1.
    - First rising edge of CLKout occurs cur_half+1 cycles after entering RUN.
  - RUN: cnt increments each cycle; at cnt==cur_half, cnt<=0 and CLKout toggles.
    - Rising toggle (0->1): no parameter changes take effect.
    - Falling toggle (1->0): commit boundary. slow_active<=slow_req and the pending fast_half is applied.
    - Also at falling toggle: if run_req=0, go to PARKED and clk_running<=0.
- Glitch-free rule: mode/divisor/stop changes only at falling commit boundaries or while PARKED. Every high and low phase of CLKout lasts exactly the old or new cur_half+1 cycles, never a runt.
- div_load:
  - Captures div_value into a pending register in any state.
  - Pending value is copied to fast_half at the next commit boundary, or the next cycle if PARKED.
  - Multiple loads before a boundary: last wins.
  - div_load coincident with a commit boundary: the new value takes effect at the following boundary.
- clk_en dropped while CLKout high: high phase completes, then CLKout parks low.
- clk_en toggled 0->1->0 within one phase: only the value sampled at the boundary matters.
- State changes mid-phase: ignored until the commit boundary.
- Counter wrap: cnt never exceeds cur_half. If cur_half shrinks below cnt, that is impossible because changes only apply at cnt=0.
- Reset mid-operation: all outputs return to reset values immediately (async); pending divisor is lost.

Optional Feature:
- Macro SD_CLK_EDGE_STROBE_EN.
- Defined: rise_stb/fall_stb pulse 1 CLKin cycle, in the cycle before CLKout goes 1/0 respectively (cnt==cur_half in RUN).
  - No fall_stb when leaving PARKED.
  - These strobes let the datapath launch/sample synchronously without using CLKout as a clock.
- Undefined: both ports tied 0; strobe logic not compiled.

Decomposition:
- Shared package sd_clk_pkg:
  - run/park state encoding typedef.
  - Default constants SD_SLOW_HALF, SD_FAST_HALF_RST, SD_SLOW_STATE_LIM for reuse by the SD controller.
- One natural sub-module, sd_clk_halfcnt:
  - Loadable half-period counter with terminal-count output.
  - Parent owns mode/commit logic.

Test Plan:
- Reset release, clk_en=1, State=8'h10 -> CLKout high/low phases of 64 CLKin cycles each; slow_active=1.
- State=8'h00 and 8'h70 with defaults -> phases of 2 cycles each (25 MHz from 100 MHz); slow_active=0 only after first falling edge following the State change.
- Switch State 8'h10->8'h80 mid high phase at cnt=20 -> high phase still 64 cycles; next low phase 2 cycles; no phase <2 cycles anywhere.
- div_load with div_value=4 during RUN fast -> current phases stay 2; after next falling edge phases are 5 cycles. div_value=0 -> 1-cycle phases.
- clk_en=0 asserted while CLKout high -> high completes, CLKout stays 0, clk_running=0. clk_en=1 -> first rise after cur_half+1 cycles.
- Reset asserted mid high phase -> CLKout=0 and slow_active=1 with no clock edge. With SD_CLK_EDGE_STROBE_EN defined, rise_stb/fall_stb lead each CLKout edge by exactly 1 cycle throughout all scenarios above.
